// File: rtl/jtframe_sdram_resp_pkg.sv
// rtl/jtframe_sdram_resp_pkg.sv - shared state encoding and bus widths for the SDRAM responder
package jtframe_sdram_resp_pkg;

    localparam int SDRAM_AW = 22;
    localparam int SDRAM_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DST,
        ST_RDY,
        ST_WRITE,
        ST_REFRESH
    } state_t;

endpackage

// File: rtl/jtframe_sdram_resp_ref.sv
// rtl/jtframe_sdram_resp_ref.sv - free-running refresh timer raising a sticky refresh-pending flag
module jtframe_sdram_resp_ref #(
    parameter int REF_PERIOD = 390
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic pend
);

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [CW-1:0] cnt;

    // A new period elapsing wins over a simultaneous clear so no refresh is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else if (cnt == CW'(REF_PERIOD - 1)) begin
            cnt  <= '0;
            pend <= 1'b1;
        end else begin
            cnt <= cnt + CW'(1);
            if (clr) pend <= 1'b0;
        end
    end

endmodule

// File: rtl/jtframe_sdram_resp.sv
// rtl/jtframe_sdram_resp.sv - SDRAM read/download-write responder; refresh enabled by JTFRAME_SDRAM_REF_EN
module jtframe_sdram_resp
    import jtframe_sdram_resp_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int REF_PERIOD = 390,
    parameter int REF_LEN    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sdram_req,
    input  logic [SDRAM_AW-1:0] sdram_addr,
    output logic                sdram_ack,
    output logic                data_dst,
    output logic                data_rdy,
    output logic [SDRAM_DW-1:0] data_read,
    input  logic                downloading,
    input  logic [SDRAM_AW-1:0] prog_addr,
    input  logic [7:0]          prog_data,
    input  logic [1:0]          prog_mask,
    input  logic                prog_we,
    output logic [SDRAM_AW-1:0] mem_addr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [1:0]          mem_be,
    output logic [SDRAM_DW-1:0] mem_din,
    input  logic [SDRAM_DW-1:0] mem_dout,
    output logic                mem_ref
);

    state_t              st, st_nxt;
    logic [2:0]          lat_cnt;
    logic [SDRAM_AW-1:0] addr_r;
    logic [SDRAM_DW-1:0] din_r;
    logic [SDRAM_DW-1:0] dread_r;
    logic [1:0]          be_r;
    logic                idle, ref_pend, rd_go, wr_go;

    assign idle  = (st == ST_IDLE);
    // Acceptance is combinational so ack/strobes land in the request cycle; gated by rst to stay 0 in reset.
    assign wr_go = rst & idle & ~ref_pend & downloading & prog_we;
    assign rd_go = rst & idle & ~ref_pend & ~downloading & sdram_req;

`ifdef JTFRAME_SDRAM_REF_EN
    localparam int RW = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;
    logic [RW-1:0] ref_cnt;

    jtframe_sdram_resp_ref #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle & ref_pend),
        .pend (ref_pend)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ref_cnt <= '0;
        else      ref_cnt <= (st == ST_REFRESH) ? ref_cnt + RW'(1) : '0;
    end

    assign mem_ref = (st == ST_REFRESH);
`else
    // The timing parameters only shape the refresh path, which is compiled out here.
    assign ref_pend = (REF_PERIOD < 1) && (REF_LEN < 1);
    assign mem_ref  = 1'b0;
`endif

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: begin
                if (ref_pend)   st_nxt = ST_REFRESH;
                else if (wr_go) st_nxt = ST_WRITE;
                else if (rd_go) st_nxt = ST_READ;
            end
            ST_READ:  if (lat_cnt == 3'(RD_LAT - 1)) st_nxt = ST_DST;
            ST_DST:   st_nxt = ST_RDY;
            ST_RDY:   st_nxt = ST_IDLE;
            ST_WRITE: st_nxt = ST_IDLE;
            ST_REFRESH: begin
`ifdef JTFRAME_SDRAM_REF_EN
                if (ref_cnt == RW'(REF_LEN - 1)) st_nxt = ST_IDLE;
`else
                st_nxt = ST_IDLE;
`endif
            end
            default:  st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= ST_IDLE;
            lat_cnt <= '0;
            addr_r  <= '0;
            din_r   <= '0;
            be_r    <= '0;
            dread_r <= '0;
        end else begin
            st      <= st_nxt;
            lat_cnt <= (st == ST_READ) ? lat_cnt + 3'd1 : 3'd0;
            if (rd_go) addr_r <= sdram_addr;
            if (wr_go) begin
                addr_r <= prog_addr;
                din_r  <= {prog_data, prog_data};
                be_r   <= ~prog_mask;
            end
            if (st == ST_DST) dread_r <= mem_dout;
        end
    end

    assign sdram_ack = rd_go | wr_go;
    assign mem_rd    = rd_go;
    assign mem_wr    = wr_go;
    assign mem_addr  = wr_go ? prog_addr : (rd_go ? sdram_addr : addr_r);
    assign mem_din   = wr_go ? {prog_data, prog_data} : din_r;
    assign mem_be    = wr_go ? ~prog_mask : be_r;
    assign data_dst  = (st == ST_DST);
    assign data_rdy  = (st == ST_RDY);
    assign data_read = dread_r;

endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// tb/tb_jtframe_sdram_resp.sv - self-checking bench for jtframe_sdram_resp
module tb_jtframe_sdram_resp;

    localparam int RD_LAT     = 2;
    localparam int REF_PERIOD = 20;
    localparam int REF_LEN    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdram_req, downloading, prog_we;
    logic [21:0] sdram_addr, prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic [15:0] mem_dout;
    logic        sdram_ack, data_dst, data_rdy, mem_rd, mem_wr, mem_ref;
    logic [15:0] data_read, mem_din;
    logic [21:0] mem_addr;
    logic [1:0]  mem_be;
    logic [61:0] all_out;

    int tests = 0;
    int fails = 0;

    jtframe_sdram_resp #(
        .RD_LAT     (RD_LAT),
        .REF_PERIOD (REF_PERIOD),
        .REF_LEN    (REF_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_dst    (data_dst),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .downloading (downloading),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_be      (mem_be),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_ref     (mem_ref)
    );

    always #5 clk = ~clk;

    assign all_out = {sdram_ack, data_dst, data_rdy, data_read, mem_addr,
                      mem_rd, mem_wr, mem_be, mem_din, mem_ref};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Leaves the bench in cycle 0 after release: the refresh timer starts counting at the next edge.
    task automatic do_reset();
        rst = 1'b0;
        sdram_req = 1'b0; downloading = 1'b0; prog_we = 1'b0;
        sdram_addr = '0; prog_addr = '0; prog_data = '0; prog_mask = '0; mem_dout = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sdram_req = 1'b1; downloading = 1'b1; prog_we = 1'b1;
        sdram_addr = 22'h3FFFFF; prog_addr = 22'h155555; prog_data = 8'hFF; prog_mask = 2'b00;
        mem_dout = 16'hFFFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (all_out !== 62'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected %h", all_out, 62'd0);
        end
    endtask

    task automatic test_read(input logic [21:0] a, input logic [15:0] d);
        do_reset();
        sdram_req = 1'b1; sdram_addr = a; mem_dout = ~d;
        @(negedge clk);
        tests++;
        if ({sdram_ack, mem_rd, mem_wr, data_dst, data_rdy, mem_addr} !== {5'b11000, a}) begin
            fails++;
            $display("FAIL read_accept: got %h expected %h",
                     {sdram_ack, mem_rd, mem_wr, data_dst, data_rdy, mem_addr}, {5'b11000, a});
        end
        @(posedge clk);
        #1 sdram_req = 1'b0; sdram_addr = ~a;
        for (int k = 1; k <= RD_LAT + 2; k++) begin
            if (k == RD_LAT) mem_dout = d;
            @(negedge clk);
            tests++;
            if ({sdram_ack, mem_rd, data_dst, data_rdy, mem_addr} !==
                {2'b00, k == RD_LAT + 1, k == RD_LAT + 2, a}) begin
                fails++;
                $display("FAIL read_phase%0d: got %h expected %h", k,
                         {sdram_ack, mem_rd, data_dst, data_rdy, mem_addr},
                         {2'b00, k == RD_LAT + 1, k == RD_LAT + 2, a});
            end
            if (k == RD_LAT + 2) begin
                tests++;
                if (data_read !== d) begin
                    fails++;
                    $display("FAIL read_data: got %h expected %h", data_read, d);
                end
            end
            @(posedge clk);
            #1;
            if (k == RD_LAT + 1) mem_dout = ~d;
        end
        @(negedge clk);
        tests++;
        if ({sdram_ack, data_rdy, data_read} !== {2'b00, d}) begin
            fails++;
            $display("FAIL read_hold: got %h expected %h", {sdram_ack, data_rdy, data_read}, {2'b00, d});
        end
    endtask

    task automatic test_write(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
        do_reset();
        downloading = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d; prog_mask = m;
        @(negedge clk);
        tests++;
        if ({sdram_ack, mem_rd, mem_wr, mem_addr, mem_din, mem_be} !== {3'b101, a, d, d, ~m}) begin
            fails++;
            $display("FAIL write_accept: got %h expected %h",
                     {sdram_ack, mem_rd, mem_wr, mem_addr, mem_din, mem_be}, {3'b101, a, d, d, ~m});
        end
        @(posedge clk);
        #1 prog_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({sdram_ack, mem_wr, mem_rd} !== 3'b000) begin
                fails++;
                $display("FAIL write_single_ack%0d: got %b expected 000", k, {sdram_ack, mem_wr, mem_rd});
            end
        end
        downloading = 1'b0;
    endtask

    task automatic test_ignored_we();
        do_reset();
        prog_we = 1'b1; prog_addr = 22'h000ABC; prog_data = 8'h33;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if ({sdram_ack, mem_wr, mem_rd} !== 3'b000) begin
                fails++;
                $display("FAIL ignored_we%0d: got %b expected 000", k, {sdram_ack, mem_wr, mem_rd});
            end
        end
        prog_we = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        downloading = 1'b1; prog_we = 1'b1; sdram_req = 1'b1;
        prog_addr = 22'($urandom); sdram_addr = ~prog_addr; prog_data = 8'($urandom); prog_mask = 2'b01;
        @(negedge clk);
        tests++;
        if ({sdram_ack, mem_rd, mem_wr, mem_addr} !== {3'b101, prog_addr}) begin
            fails++;
            $display("FAIL priority_write: got %h expected %h",
                     {sdram_ack, mem_rd, mem_wr, mem_addr}, {3'b101, prog_addr});
        end
        @(posedge clk);
        #1 prog_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests++;
            if ({sdram_ack, mem_rd} !== 2'b00) begin
                fails++;
                $display("FAIL priority_no_read%0d: got %b expected 00", k, {sdram_ack, mem_rd});
            end
        end
        sdram_req = 1'b0; downloading = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n_ack = 0;
        int n_rdy = 0;
        int ack_cyc [3];
        do_reset();
        sdram_req = 1'b1; sdram_addr = 22'($urandom); mem_dout = 16'($urandom);
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (sdram_ack) begin
                if (n_ack < 3) ack_cyc[n_ack] = c;
                n_ack++;
            end
            if (data_rdy) n_rdy++;
            @(posedge clk);
            #1;
            if (n_ack >= 3) sdram_req = 1'b0;
        end
        tests++;
        if (n_ack !== 3) begin
            fails++;
            $display("FAIL b2b_ack_count: got %0d expected 3", n_ack);
        end
        tests++;
        if (n_rdy !== 3) begin
            fails++;
            $display("FAIL b2b_rdy_count: got %0d expected 3", n_rdy);
        end
        if (n_ack >= 3) begin
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (ack_cyc[i+1] - ack_cyc[i] !== RD_LAT + 3) begin
                    fails++;
                    $display("FAIL b2b_spacing%0d: got %0d expected %0d", i,
                             ack_cyc[i+1] - ack_cyc[i], RD_LAT + 3);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int seen = 0;
        do_reset();
        sdram_req = 1'b1; sdram_addr = 22'h2AAAAA; mem_dout = 16'h1234;
        @(posedge clk);
        #1 sdram_req = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (all_out !== 62'd0) begin
            fails++;
            $display("FAIL midread_reset_outputs: got %h expected %h", all_out, 62'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < RD_LAT + 4; k++) begin
            @(negedge clk);
            if (data_dst || data_rdy || sdram_ack) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midread_no_data: got %0d strobes expected 0", seen);
        end
    endtask

`ifdef JTFRAME_SDRAM_REF_EN
    // Refresh comes due (cycle 20) while a read accepted at cycle 17 is still in flight.
    task automatic test_refresh();
        int n_ack = 0;
        int ack2 = -1;
        int rdy_c = -1;
        int ref_start = -1;
        int ref_last = -1;
        int ref_n = 0;
        int ref_early = 0;
        do_reset();
        repeat (17) @(posedge clk);
        #1 sdram_req = 1'b1; sdram_addr = 22'h00321; mem_dout = 16'h0F0F;
        for (int c = 17; c <= 34; c++) begin
            @(negedge clk);
            if (sdram_ack) begin
                n_ack++;
                if (n_ack == 2) ack2 = c;
            end
            if (data_rdy && rdy_c < 0) rdy_c = c;
            if (mem_ref) begin
                if (rdy_c < 0) ref_early++;
                if (ref_start < 0) ref_start = c;
                ref_last = c;
                ref_n++;
            end
            @(posedge clk);
            #1;
            if (n_ack >= 2) sdram_req = 1'b0;
        end
        tests++;
        if (ref_early !== 0) begin
            fails++;
            $display("FAIL refresh_during_read: got %0d cycles expected 0", ref_early);
        end
        tests++;
        if (ref_start !== rdy_c + 1) begin
            fails++;
            $display("FAIL refresh_start: got cycle %0d expected %0d", ref_start, rdy_c + 1);
        end
        tests++;
        if (ref_n !== REF_LEN || ref_last - ref_start + 1 !== REF_LEN) begin
            fails++;
            $display("FAIL refresh_len: got %0d cycles expected %0d", ref_n, REF_LEN);
        end
        tests++;
        if (ack2 !== ref_start + REF_LEN) begin
            fails++;
            $display("FAIL refresh_pending_ack: got cycle %0d expected %0d", ack2, ref_start + REF_LEN);
        end
    endtask
`else
    task automatic test_refresh();
        int seen = 0;
        do_reset();
        for (int c = 0; c < 3 * REF_PERIOD; c++) begin
            @(negedge clk);
            if (mem_ref) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL no_refresh: got %0d mem_ref cycles expected 0", seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read(22'h00123, 16'hBEEF);
        for (int i = 0; i < 6; i++) test_read(22'($urandom), 16'($urandom));
        test_write(22'h00010, 8'h5A, 2'b10);
        for (int i = 0; i < 5; i++) test_write(22'($urandom), 8'($urandom), 2'($urandom));
        test_ignored_we();
        test_priority();
        test_back_to_back();
        test_reset_mid_read();
        test_refresh();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
